uart_tx: RTL and testbench

Serial UART transmitter that drains the byte FIFO as its sole reader and shifts each byte onto `tx` as one asynchronous frame: start bit, data LSB first, optional parity, stop bit(s). It sits between the FIFO's read port (`rd_en`, `data_out`, `empty`) and the device pin. It pops one word at a time and pops the next word only after the current frame's stop bit completes.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_baud_gen.sv | 49 ++++
 rtl/uart_tx.sv | 196 +++++++++++++++++++
 tb/tb_uart_tx.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmitter slice.
//   uart_tx_state_t      : transmitter FSM states
//   DEFAULT_CLKS_PER_BIT : default clk cycles per serial bit
//   LINE_IDLE            : level of the serial line when nothing is sent
// ---------------------------------------------------------------------------
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      LOAD,
      START,
      DATA,
      PARITY,
      STOP
   } uart_tx_state_t;

   localparam int DEFAULT_CLKS_PER_BIT = 868;

   localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/uart_baud_gen.sv
// ---------------------------------------------------------------------------
// uart_baud_gen
// Bit-period timer for the UART transmitter. Counts 0..CLKS_PER_BIT-1 while
// enabled and flags the last cycle of every bit period.
//   clk      in  system clock, rising edge
//   rst_n    in  asynchronous active-low reset
//   enable   in  count while high (a bit is on the line)
//   restart  in  clear the counter to 0 on the next edge
//   bit_tick out one-cycle pulse during the terminal count
// ---------------------------------------------------------------------------
module uart_baud_gen
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic enable,
   input  logic restart,
   output logic bit_tick
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] count;

   // The counter is cleared by restart so that the first bit of a frame
   // gets a full period, then wraps at the terminal count so consecutive
   // bits are exactly CLKS_PER_BIT cycles apart.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (restart) begin
         count <= '0;
      end else if (enable) begin
         if (count == TERMINAL) begin
            count <= '0;
         end else begin
            count <= count + 1'b1;
         end
      end
   end

   // The tick marks the last cycle of the current bit; the FSM uses it to
   // put the next bit on the line at the following edge.
   assign bit_tick = enable && !restart && (count == TERMINAL);

endmodule

// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx
// UART transmitter draining a byte FIFO as its only reader. Each word is sent
// as start bit, data LSB first, optional even parity, then STOP_BITS stop
// bits. The next word is popped only after the current frame has finished.
//   clk        in  system clock, rising edge
//   rst_n      in  asynchronous active-low reset
//   fifo_empty in  FIFO empty flag, looked at only while idle
//   fifo_data  in  FIFO read data, valid the cycle after a pop
//   fifo_rd_en out registered single-cycle pop request
//   tx         out serial line, idles high
//   busy       out high whenever the FSM is not idle
//   tx_done    out one-cycle pulse after the last stop bit
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit after
// the data bits.
// ---------------------------------------------------------------------------
module uart_tx
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH   = 8,
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int STOP_BITS    = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   output logic                  fifo_rd_en,
   output logic                  tx,
   output logic                  busy,
   output logic                  tx_done
);

   localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);
   localparam logic LAST_STOP = 1'(STOP_BITS - 1);

   uart_tx_state_t state, state_next;

   logic [DATA_WIDTH-1:0] shift_reg, shift_reg_next;
   logic [IDX_W-1:0]      bit_idx, bit_idx_next;
   logic                  stop_cnt, stop_cnt_next;
   logic                  tx_next;
   logic                  rd_en_next;
   logic                  done_next;
   logic                  bit_tick;
   logic                  baud_enable;
   logic                  baud_restart;

`ifdef UART_TX_PARITY_EN
   logic                  parity_bit, parity_bit_next;
`endif

   // The bit timer only runs while a bit is on the line; LOAD clears it so
   // the start bit begins with a fresh count.
   assign baud_enable  = (state == START) || (state == DATA) ||
                         (state == PARITY) || (state == STOP);
   assign baud_restart = (state == LOAD);

   uart_baud_gen #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud_gen (
      .clk      (clk),
      .rst_n    (rst_n),
      .enable   (baud_enable),
      .restart  (baud_restart),
      .bit_tick (bit_tick)
   );

   assign busy = (state != IDLE);

   // State and datapath registers. Everything resets asynchronously so the
   // line snaps back high the moment reset is asserted, dropping any
   // partially sent byte.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         tx         <= LINE_IDLE;
         fifo_rd_en <= 1'b0;
         tx_done    <= 1'b0;
         shift_reg  <= '0;
         bit_idx    <= '0;
         stop_cnt   <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_bit <= 1'b0;
`endif
      end else begin
         state      <= state_next;
         tx         <= tx_next;
         fifo_rd_en <= rd_en_next;
         tx_done    <= done_next;
         shift_reg  <= shift_reg_next;
         bit_idx    <= bit_idx_next;
         stop_cnt   <= stop_cnt_next;
`ifdef UART_TX_PARITY_EN
         parity_bit <= parity_bit_next;
`endif
      end
   end

   // Next-state and output decode. The pop is issued from IDLE only, so the
   // FIFO is never read while empty and at most one pop is outstanding. The
   // word arrives during FETCH and is captured in LOAD together with the
   // falling edge of the start bit. Each bit is advanced on bit_tick, which
   // keeps every level on the line for exactly one bit period.
   always_comb begin
      state_next     = state;
      tx_next        = tx;
      rd_en_next     = 1'b0;
      done_next      = 1'b0;
      shift_reg_next = shift_reg;
      bit_idx_next   = bit_idx;
      stop_cnt_next  = stop_cnt;
`ifdef UART_TX_PARITY_EN
      parity_bit_next = parity_bit;
`endif

      case (state)
         IDLE: begin
            tx_next = LINE_IDLE;
            if (!fifo_empty) begin
               rd_en_next = 1'b1;
               state_next = FETCH;
            end
         end

         FETCH: begin
            state_next = LOAD;
         end

         LOAD: begin
            shift_reg_next = fifo_data;
`ifdef UART_TX_PARITY_EN
            parity_bit_next = ^fifo_data;
`endif
            tx_next    = 1'b0;
            state_next = START;
         end

         START: begin
            if (bit_tick) begin
               tx_next        = shift_reg[0];
               shift_reg_next = shift_reg >> 1;
               bit_idx_next   = '0;
               state_next     = DATA;
            end
         end

         DATA: begin
            if (bit_tick) begin
               if (bit_idx == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
                  tx_next    = parity_bit;
                  state_next = PARITY;
`else
                  tx_next       = LINE_IDLE;
                  stop_cnt_next = 1'b0;
                  state_next    = STOP;
`endif
               end else begin
                  tx_next        = shift_reg[0];
                  shift_reg_next = shift_reg >> 1;
                  bit_idx_next   = bit_idx + 1'b1;
               end
            end
         end

`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (bit_tick) begin
               tx_next       = LINE_IDLE;
               stop_cnt_next = 1'b0;
               state_next    = STOP;
            end
         end
`endif

         STOP: begin
            if (bit_tick) begin
               if (stop_cnt == LAST_STOP) begin
                  done_next  = 1'b1;
                  state_next = IDLE;
               end else begin
                  stop_cnt_next = stop_cnt + 1'b1;
               end
            end
         end

         default: begin
            tx_next    = LINE_IDLE;
            state_next = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_tx
// Directed bench for uart_tx with CLKS_PER_BIT=4. Instance dut uses one stop
// bit, dut2 uses two. Each instance is fed by a small queue-based FIFO model.
// Build option: UART_TX_PARITY_EN (frames then carry an even-parity bit).
// ---------------------------------------------------------------------------
module tb_uart_tx;

   localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
   localparam int PBITS = 1;
`else
   localparam int PBITS = 0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;

   logic       fifo_empty = 1'b1;
   logic [7:0] fifo_data = '0;
   logic       rd_en, tx, busy, tx_done;

   logic       fifo_empty2 = 1'b1;
   logic [7:0] fifo_data2 = '0;
   logic       rd_en2, tx2, busy2, tx_done2;

   logic       push0 = 1'b0, push1 = 1'b0;
   logic [7:0] push_data0 = '0, push_data1 = '0;
   logic [7:0] q0[$];
   logic [7:0] q1[$];

   int         underflow0 = 0, underflow1 = 0;
   int         rd_cycles = 0, done_cycles = 0, rd_while_empty = 0;

   int         checks = 0;
   int         failures = 0;

   logic       cur_tx, cur_busy, cur_done;

   always #5 clk = ~clk;

   uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .fifo_empty (fifo_empty),
      .fifo_data  (fifo_data),
      .fifo_rd_en (rd_en),
      .tx         (tx),
      .busy       (busy),
      .tx_done    (tx_done)
   );

   uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut2 (
      .clk        (clk),
      .rst_n      (rst_n),
      .fifo_empty (fifo_empty2),
      .fifo_data  (fifo_data2),
      .fifo_rd_en (rd_en2),
      .tx         (tx2),
      .busy       (busy2),
      .tx_done    (tx_done2)
   );

   // FIFO model for dut: pops on rd_en with data valid the next cycle,
   // counts any pop attempted on an empty queue, and keeps a registered
   // empty flag like a real synchronous FIFO.
   always @(posedge clk) begin
      if (rd_en) begin
         if (q0.size() == 0) underflow0++;
         else fifo_data <= q0.pop_front();
      end
      if (push0) q0.push_back(push_data0);
      fifo_empty <= (q0.size() == 0);
   end

   // Same FIFO model for the two-stop-bit instance.
   always @(posedge clk) begin
      if (rd_en2) begin
         if (q1.size() == 0) underflow1++;
         else fifo_data2 <= q1.pop_front();
      end
      if (push1) q1.push_back(push_data1);
      fifo_empty2 <= (q1.size() == 0);
   end

   // Event counters for dut, sampled mid-cycle: pop cycles, done pulses and
   // any pop requested while the FIFO reports empty.
   always @(negedge clk) begin
      if (rst_n) begin
         if (rd_en) rd_cycles++;
         if (tx_done) done_cycles++;
         if (rd_en && fifo_empty) rd_while_empty++;
      end
   end

   // Hard stop in case the stimulus ever stalls.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input int which, input logic [7:0] b);
      if (which == 0) begin
         push0 = 1'b1;
         push_data0 = b;
      end else begin
         push1 = 1'b1;
         push_data1 = b;
      end
      @(negedge clk);
      push0 = 1'b0;
      push1 = 1'b0;
   endtask

   task automatic sample(input int which);
      @(negedge clk);
      if (which == 0) begin
         cur_tx = tx; cur_busy = busy; cur_done = tx_done;
      end else begin
         cur_tx = tx2; cur_busy = busy2; cur_done = tx_done2;
      end
   endtask

   // Waits (bounded) for the start bit; highs is the number of high samples
   // seen before it, and the last sample taken is the first start-bit cycle.
   task automatic waitStart(input string tag, input int which, output int highs);
      logic found;
      found = 1'b0;
      highs = 0;
      for (int i = 0; i < 60 && !found; i++) begin
         sample(which);
         if (cur_tx === 1'b0) found = 1'b1;
         else highs++;
      end
      checkOutput({tag, "_start_seen"}, 32'(found), 32'd1);
   endtask

   // Checks that every bit holds its level for exactly CPB samples.
   task automatic checkFrame(input string tag, input int which, input int nbits,
                             input logic [15:0] levels);
      logic [3:0] pat;
      for (int i = 0; i < nbits; i++) begin
         pat = '0;
         for (int s = 0; s < CPB; s++) begin
            if (!(i == 0 && s == 0)) sample(which);
            pat = {pat[2:0], cur_tx};
         end
         checkOutput($sformatf("%s_bit%0d", tag, i), 32'(pat),
                     levels[i] ? 32'hF : 32'h0);
      end
   endtask

   // The cycle after the last stop bit: done pulse, idle, line high.
   task automatic checkDone(input string tag, input int which);
      sample(which);
      checkOutput({tag, "_done"}, 32'({cur_done, cur_busy, cur_tx}), 32'b101);
   endtask

   // Line levels in transmit order: start, data LSB first, parity (when
   // built in), stop bits. The parity argument is the hand-computed value.
   function automatic logic [15:0] frameLevels(input logic [7:0] d,
                                               input logic par, input int stops);
      logic [15:0] lv;
      int idx;
      lv = '0;
      lv[8:1] = d;
      idx = 9;
`ifdef UART_TX_PARITY_EN
      lv[9] = par;
      idx = 10;
`else
      if (par) lv[15] = 1'b0;
`endif
      for (int s = 0; s < stops; s++) lv[idx + s] = 1'b1;
      return lv;
   endfunction

   // Main directed sequence.
   initial begin
      int highs;
      int rd0, done0;
      int nb1, nb2;
      int bad;

      nb1 = 10 + PBITS;
      nb2 = 11 + PBITS;

      repeat (3) @(negedge clk);
      checkOutput("reset_values", 32'({tx, rd_en, busy, tx_done}), 32'b1000);
      rst_n = 1'b1;

      bad = 0;
      for (int i = 0; i < 100; i++) begin
         sample(0);
         if (cur_tx !== 1'b1 || rd_en !== 1'b0 || cur_busy !== 1'b0) bad++;
      end
      checkOutput("idle_100", 32'(bad), 32'd0);

      $display("[TB] single byte 0xA5");
      rd0 = rd_cycles;
      done0 = done_cycles;
      applyStimulus(0, 8'hA5);
      waitStart("a5", 0, highs);
      checkOutput("a5_latency", 32'(highs), 32'd2);
      checkFrame("a5", 0, nb1, frameLevels(8'hA5, 1'b0, 1));
      checkDone("a5", 0);
      sample(0);
      sample(0);
      checkOutput("a5_pops", 32'(rd_cycles - rd0), 32'd1);
      checkOutput("a5_done_pulses", 32'(done_cycles - done0), 32'd1);

      $display("[TB] back-to-back 0x00, 0xFF");
      rd0 = rd_cycles;
      applyStimulus(0, 8'h00);
      applyStimulus(0, 8'hFF);
      waitStart("b00", 0, highs);
      checkFrame("b00", 0, nb1, frameLevels(8'h00, 1'b0, 1));
      checkDone("b00", 0);
      waitStart("bff", 0, highs);
      checkOutput("b2b_gap", 32'(highs + 1), 32'd3);
      checkFrame("bff", 0, nb1, frameLevels(8'hFF, 1'b0, 1));
      checkDone("bff", 0);
      sample(0);
      checkOutput("b2b_pops", 32'(rd_cycles - rd0), 32'd2);

      $display("[TB] byte 0x07");
      applyStimulus(0, 8'h07);
      waitStart("b07", 0, highs);
      checkFrame("b07", 0, nb1, frameLevels(8'h07, 1'b1, 1));
      checkDone("b07", 0);

      $display("[TB] two stop bits, 0x3C");
      applyStimulus(1, 8'h3C);
      waitStart("s2", 1, highs);
      checkFrame("s2", 1, nb2, frameLevels(8'h3C, 1'b0, 2));
      checkDone("s2", 1);

      $display("[TB] reset during data bit 3");
      applyStimulus(0, 8'hC3);
      waitStart("rst", 0, highs);
      repeat (17) sample(0);
      checkOutput("rst_pre_tx", 32'(cur_tx), 32'd0);
      rst_n = 1'b0;
      #1;
      checkOutput("rst_async", 32'({tx, busy}), 32'b10);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(0, 8'h55);
      waitStart("r55", 0, highs);
      checkFrame("r55", 0, nb1, frameLevels(8'h55, 1'b0, 1));
      checkDone("r55", 0);

      repeat (4) sample(0);
      checkOutput("no_underflow", 32'(underflow0 + underflow1), 32'd0);
      checkOutput("no_pop_when_empty", 32'(rd_while_empty), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
